ysyx_220053_ifid: RTL and testbench
===================================

# ysyx_220053_ifid

IF/ID decoupling buffer between the instruction fetch stage and the decode stage of the RV64 core. Captures each fetched {pc, instruction} beat from the fetch unit into a small FIFO and presents the oldest entry to decode with valid/ready handshakes on both sides. Predecodes register indices, next sequential PC and a control-flow flag, and drops all buffered state on a redirect flush.

## Interface
- `DEPTH`, 2: entry count; power of two, ≥2
- `XLEN`, 64: PC width
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-low reset
- `in_valid` in 1: fetch beat valid
- `in_ready` out 1: buffer can accept a beat
- `in_pc` in XLEN: PC of fetched instruction
- `in_instr` in 32: fetched instruction
- `flush` in 1: redirect; discard all entries and any same-cycle input
- `out_valid` out 1: head entry valid
- `out_ready` in 1: decode accepts head
- `out_pc` out XLEN: head PC
- `out_instr` out 32: head instruction
- `out_snpc` out XLEN: `out_pc + 4`
- `out_rd`, `out_rs1`, `out_rs2` out 5 each: `instr[11:7]`, `[19:15]`, `[24:20]`
- `out_is_ctrl` out 1: opcode is JAL (1101111), JALR (1100111) or BRANCH (1100011)
- `count` out $clog2(DEPTH)+1: occupied entries

## Operation
- Circular buffer; read/write pointers are $clog2(DEPTH)+1 bits, the MSB is the wrap bit; full = indices equal and wrap bits differ.
- `in_ready` = running (not in reset) && count < DEPTH; it does not depend on `out_ready` (no combinational ready path).
- Push = `in_valid && in_ready && !flush`; writes {in_pc, in_instr} at wptr, increments wptr.
- Pop = `out_valid && out_ready`; increments rptr.
- Push and pop in the same cycle: count unchanged, FIFO order preserved.
- `out_valid` = count != 0. Head outputs are read from storage; no input-to-output bypass.
- Empty: `out_pc` = 0, `out_instr` = 32'h00000013 (NOP); predecode fields derive from that NOP (rd = 0, rs1 = 0, is_ctrl = 0, snpc = 4).
- Flush priority: pointers and count return to 0 at the next edge. The same-cycle input beat is dropped. A pop handshake in the flush cycle has no further effect. `out_valid` is not masked combinationally by `flush`; decode ignores the head while it drives `flush`.
- `out_snpc` wraps modulo 2^XLEN.
- Storage contents are not reset; only pointers and count are.

## Timing
- Reset (rst = 0 at an edge): pointers = 0, count = 0. While `rst` is low: `out_valid` = 0, `in_ready` = 0, and the data outputs take the empty values above.
- `in_ready` = 1 in the first cycle after `rst` is sampled high.
- Latency 1 cycle: a beat pushed at edge N is visible with `out_valid` = 1 after edge N.
- Full with a pop at edge N: `in_ready` rises after edge N, not in the same cycle.
- Flush at edge N: `out_valid` = 0 and `in_ready` = 1 after edge N; a push is possible at edge N+1.
- Reset asserted mid-operation: same as flush plus the reset-value behaviour; in-flight beats are lost.

## Structure
- Shared package `ysyx_220053_pkg`:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH
  - `NOP_INSTR` = 32'h00000013
  - `ifid_entry_t` struct {pc, instr}
- Sub-module `ysyx_220053_predecode`: combinational; instr/pc → rd, rs1, rs2, snpc, is_ctrl; reused later by the decode stage.
- Top level holds the pointers, the storage array and the handshake logic.

## Test plan
- Reset: hold rst = 0 for 2 cycles with in_valid = 1 → in_ready = 0, out_valid = 0, out_instr = 0x00000013, count = 0; first cycle after release → in_ready = 1.
- Single beat: push pc 0x80000000, instr 0x00000297 → next cycle out_valid = 1, out_pc = 0x80000000, out_snpc = 0x80000004, out_rd = 5, out_is_ctrl = 0.
- Backpressure: out_ready = 0, push pcs 0x80000000 and 0x80000004 → count = 2, in_ready = 0, third beat held by fetch; set out_ready = 1 → drains in order, in_ready = 1 the cycle after the first pop.
- Concurrent: count = 1, push and pop at the same edge for 5 consecutive cycles → count stays 1, order exact, pointers wrap correctly.
- Flush: count = 2, in_valid = 1, flush = 1 for one cycle → next cycle count = 0, out_valid = 0, dropped beat never appears.
- Edge values: push pc 0xFFFFFFFFFFFFFFFC with instr 0x0000006F (jal) → out_snpc = 0, out_is_ctrl = 1; instr 0x00008067 (jalr) → out_is_ctrl = 1, out_rs1 = 1.

Source files
------------

// File: rtl/ysyx_220053_pkg.sv
// Definitions shared by the IF/ID buffer and the decode stage: opcodes,
// the canonical NOP and the buffered fetch-beat record.
package ysyx_220053_pkg;

  localparam int PC_W = 64;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } ifid_entry_t;

endpackage

// File: rtl/ysyx_220053_predecode.sv
// Combinational predecode of one instruction: register fields, next
// sequential PC and a control-flow flag.
module ysyx_220053_predecode
  import ysyx_220053_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] snpc,
  output logic            is_ctrl
);

  logic [6:0] opcode;

  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  // Wraps modulo 2^XLEN by construction of the adder width.
  assign snpc    = pc + XLEN'(4);
  assign is_ctrl = (opcode == OP_JAL) || (opcode == OP_JALR) ||
                   (opcode == OP_BRANCH);

endmodule

// File: rtl/ysyx_220053_ifid.sv
// IF/ID decoupling FIFO: buffers fetched {pc, instr} beats, presents the
// oldest one to decode with predecoded fields, and empties on a redirect.
module ysyx_220053_ifid
  import ysyx_220053_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [31:0]            in_instr,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_instr,
  output logic [XLEN-1:0]        out_snpc,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic                   out_is_ctrl,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wptr, rptr;
  logic [AW-1:0] widx, ridx;
  logic          full, empty, push, pop;
  ifid_entry_t   mem [DEPTH];

  assign widx  = wptr[AW-1:0];
  assign ridx  = rptr[AW-1:0];
  assign full  = (widx == ridx) && (wptr[AW] != rptr[AW]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;

  // rst doubles as the "running" qualifier so nothing handshakes in reset.
  assign in_ready  = rst && !full;
  assign out_valid = rst && !empty;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage is data only; it is never reset.
  always_ff @(posedge clk) begin
    if (push) mem[widx] <= '{pc: PC_W'(in_pc), instr: in_instr};
  end

  // An empty buffer presents a NOP at pc 0 so predecode outputs stay benign.
  assign out_pc    = out_valid ? XLEN'(mem[ridx].pc) : '0;
  assign out_instr = out_valid ? mem[ridx].instr : NOP_INSTR;

  ysyx_220053_predecode #(.XLEN(XLEN)) u_predecode (
    .instr   (out_instr),
    .pc      (out_pc),
    .rd      (out_rd),
    .rs1     (out_rs1),
    .rs2     (out_rs2),
    .snpc    (out_snpc),
    .is_ctrl (out_is_ctrl)
  );

endmodule

// File: tb/tb_ysyx_220053_ifid.sv
// Bench for the IF/ID buffer: predecode vector table plus scoreboarded
// handshake sequences (backpressure, concurrent push/pop, flush, reset).
module tb_ysyx_220053_ifid;

  localparam int DEPTH = 2;
  localparam int XLEN  = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_snpc;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic            out_is_ctrl;
  logic [1:0]      count;

  ysyx_220053_ifid #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_snpc    (out_snpc),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_is_ctrl (out_is_ctrl),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] snpc;
    logic [4:0]  rd, rs1, rs2;
    logic        ctrl;
    bit          chk_pd;
  } exp_t;

  exp_t sbq[$];
  exp_t tbl[7];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] pc, input logic [31:0] ins);
    exp_t e;
    e.pc = pc; e.instr = ins; e.snpc = '0;
    e.rd = '0; e.rs1 = '0; e.rs2 = '0; e.ctrl = 1'b0; e.chk_pd = 1'b0;
    return e;
  endfunction

  function automatic exp_t vec(input logic [63:0] pc, input logic [31:0] ins,
                               input logic [63:0] snpc, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic ctrl);
    exp_t e;
    e.pc = pc; e.instr = ins; e.snpc = snpc;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.ctrl = ctrl; e.chk_pd = 1'b1;
    return e;
  endfunction

  // One clock: drive inputs, check the pre-edge view at negedge, then
  // advance the scoreboard by the same edge.
  task automatic cycle(input logic iv, input exp_t item, input logic fl, input logic ordy);
    int m_cnt;
    bit m_push, m_pop;
    in_valid = iv; in_pc = item.pc; in_instr = item.instr;
    flush = fl; out_ready = ordy;
    m_cnt = sbq.size();
    @(negedge clk);
    chk("count", 64'(count), 64'(m_cnt));
    chk("out_valid", 64'(out_valid), 64'(m_cnt != 0));
    chk("in_ready", 64'(in_ready), 64'(m_cnt < DEPTH));
    if (m_cnt != 0) begin
      chk("head_pc", out_pc, sbq[0].pc);
      chk("head_instr", 64'(out_instr), 64'(sbq[0].instr));
      if (sbq[0].chk_pd) begin
        chk("head_snpc", out_snpc, sbq[0].snpc);
        chk("head_rd", 64'(out_rd), 64'(sbq[0].rd));
        chk("head_rs1", 64'(out_rs1), 64'(sbq[0].rs1));
        chk("head_rs2", 64'(out_rs2), 64'(sbq[0].rs2));
        chk("head_is_ctrl", 64'(out_is_ctrl), 64'(sbq[0].ctrl));
      end
    end else begin
      chk("empty_pc", out_pc, 64'h0);
      chk("empty_instr", 64'(out_instr), 64'h13);
      chk("empty_snpc", out_snpc, 64'h4);
      chk("empty_is_ctrl", 64'(out_is_ctrl), 64'h0);
    end
    m_push = iv && (m_cnt < DEPTH) && !fl;
    m_pop  = (m_cnt != 0) && ordy;
    @(posedge clk); #1;
    if (fl) sbq.delete();
    else begin
      if (m_pop) void'(sbq.pop_front());
      if (m_push) sbq.push_back(item);
    end
  endtask

  initial begin
    tbl[0] = vec(64'h80000000, 32'h00000297, 64'h80000004, 5'd5, 5'd0, 5'd0, 1'b0);
    tbl[1] = vec(64'hFFFFFFFFFFFFFFFC, 32'h0000006F, 64'h0, 5'd0, 5'd0, 5'd0, 1'b1);
    tbl[2] = vec(64'h80000010, 32'h00008067, 64'h80000014, 5'd0, 5'd1, 5'd0, 1'b1);
    tbl[3] = vec(64'h00001000, 32'h00208463, 64'h00001004, 5'd8, 5'd1, 5'd2, 1'b1);
    tbl[4] = vec(64'h00002000, 32'h005201B3, 64'h00002004, 5'd3, 5'd4, 5'd5, 1'b0);
    tbl[5] = vec(64'h7FFFFFFFFFFFFFFC, 32'h0000006B, 64'h8000000000000000, 5'd0, 5'd0, 5'd0, 1'b0);
    tbl[6] = vec(64'h0, 32'hFFFFFFFF, 64'h4, 5'd31, 5'd31, 5'd31, 1'b0);

    // Reset held two cycles with a beat offered.
    rst = 1'b0; in_valid = 1'b1; in_pc = 64'h80000000; in_instr = 32'h00000297;
    flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_instr", 64'(out_instr), 64'h13);
      chk("rst_count", 64'(count), 64'h0);
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'h1);
    @(posedge clk); #1;

    // Predecode table, streamed back to back.
    foreach (tbl[i]) cycle(1'b1, tbl[i], 1'b0, 1'b1);
    cycle(1'b0, mk(64'h0, 32'h0), 1'b0, 1'b1);
    cycle(1'b0, mk(64'h0, 32'h0), 1'b0, 1'b1);

    // Backpressure: fill, hold the third beat, then drain in order.
    cycle(1'b1, mk(64'h80000000, 32'h00000297), 1'b0, 1'b0);
    cycle(1'b1, mk(64'h80000004, 32'h00100093), 1'b0, 1'b0);
    cycle(1'b1, mk(64'h80000008, 32'h00200113), 1'b0, 1'b0);
    cycle(1'b1, mk(64'h80000008, 32'h00200113), 1'b0, 1'b0);
    cycle(1'b1, mk(64'h80000008, 32'h00200113), 1'b0, 1'b1);
    cycle(1'b1, mk(64'h80000008, 32'h00200113), 1'b0, 1'b1);
    cycle(1'b0, mk(64'h0, 32'h0), 1'b0, 1'b1);
    cycle(1'b0, mk(64'h0, 32'h0), 1'b0, 1'b1);

    // Concurrent push/pop at count 1, wrapping the pointers.
    cycle(1'b1, mk(64'h90000000, 32'h00000013), 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++)
      cycle(1'b1, mk(64'h90000000 + 64'(4 * k), 32'h00000013 + 32'(k << 7)), 1'b0, 1'b1);
    cycle(1'b0, mk(64'h0, 32'h0), 1'b0, 1'b1);
    cycle(1'b0, mk(64'h0, 32'h0), 1'b0, 1'b1);

    // Flush with a full buffer and a beat offered.
    cycle(1'b1, mk(64'hA0000000, 32'h00000113), 1'b0, 1'b0);
    cycle(1'b1, mk(64'hA0000004, 32'h00000193), 1'b0, 1'b0);
    cycle(1'b1, mk(64'hDEAD0000, 32'h0000006F), 1'b1, 1'b1);
    cycle(1'b1, mk(64'hB0000000, 32'h00000213), 1'b0, 1'b0);
    cycle(1'b0, mk(64'h0, 32'h0), 1'b0, 1'b1);
    cycle(1'b0, mk(64'h0, 32'h0), 1'b0, 1'b1);

    // Reset mid-operation discards buffered beats.
    cycle(1'b1, mk(64'hC0000000, 32'h00000293), 1'b0, 1'b0);
    cycle(1'b1, mk(64'hC0000004, 32'h00000313), 1'b0, 1'b0);
    rst = 1'b0; in_valid = 1'b1; in_pc = 64'hC0000008; out_ready = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_in_ready", 64'(in_ready), 64'h0);
    chk("midrst_out_instr", 64'(out_instr), 64'h13);
    @(posedge clk); #1;
    sbq.delete();
    rst = 1'b1;
    cycle(1'b0, mk(64'h0, 32'h0), 1'b0, 1'b1);
    cycle(1'b1, mk(64'hD0000000, 32'h00000393), 1'b0, 1'b1);
    cycle(1'b0, mk(64'h0, 32'h0), 1'b0, 1'b1);
    cycle(1'b0, mk(64'h0, 32'h0), 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
